// File: rtl/octa_pkg.sv
// Shared decode definitions: opcode values, instruction field offsets, operand classes
// and the decoded-instruction record held in the output slot.
package octa_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ALU_R  = 4'h1;
    localparam logic [3:0] OP_ALU_I  = 4'h2;
    localparam logic [3:0] OP_LOAD   = 4'h3;
    localparam logic [3:0] OP_STORE  = 4'h4;
    localparam logic [3:0] OP_BRANCH = 4'h5;
    localparam logic [3:0] OP_JUMP   = 4'h6;

    localparam int OP_LSB    = 12;
    localparam int RD_LSB    = 10;
    localparam int RS1_LSB   = 8;
    localparam int RS2_LSB   = 6;
    localparam int IMM_W     = 6;
    localparam int REG_IDX_W = 2;

    // RR_W: two reads + write, R_W: one read + write, RR: two reads, NONE: nothing
    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_RR_W,
        CLS_R_W,
        CLS_RR
    } op_class_e;

    typedef struct packed {
        logic [3:0]           op;
        logic                 rs1_en;
        logic                 rs2_en;
        logic                 wr_en;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic [15:0]          imm;
    } dec_t;

    function automatic op_class_e op_class(input logic [3:0] op);
        case (op)
            OP_ALU_R:            return CLS_RR_W;
            OP_ALU_I, OP_LOAD:   return CLS_R_W;
            OP_STORE, OP_BRANCH: return CLS_RR;
            default:             return CLS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/decode_issue_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue,
// cleared on writeback; a simultaneous set of the same bit takes priority.
module scoreboard #(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [IDX_W-1:0]    set_idx,
    input  logic                clr_en,
    input  logic [IDX_W-1:0]    clr_idx,
    output logic [NUM_REGS-1:0] pending
);

    logic [NUM_REGS-1:0] pending_d, pending_q;

    always_comb begin
        pending_d = pending_q;
        if (clr_en) pending_d[clr_idx] = 1'b0;
        if (set_en) pending_d[set_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) pending_q <= '0;
        else     pending_q <= pending_d;
    end

    assign pending = pending_q;

endmodule

// File: rtl/decode_issue.sv
// Decode stage: splits instructions into register-file read requests, holds one decoded
// instruction for execute and stalls on RAW/WAW hazards against pending writes.
module decode_issue
    import octa_pkg::*;
#(
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 6,
    parameter int NUM_REGS    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   flush,
    output logic                   rs1_en,
    output logic                   rs2_en,
    output logic [ADDR_WIDTH-1:0]  rd_addr1,
    output logic [ADDR_WIDTH-1:0]  rd_addr2,
    output logic                   dst_wr_en,
    output logic [ADDR_WIDTH-1:0]  dst_addr,
    output logic [3:0]             op,
    output logic [15:0]            imm,
    input  logic                   wb_en,
    input  logic [ADDR_WIDTH-1:0]  wb_addr
);

    localparam int PAD_W = ADDR_WIDTH - REG_IDX_W;

    dec_t                dec;
    op_class_e           cls;
    dec_t                slot_d, slot_q;
    logic                out_valid_d, out_valid_q;
    logic [NUM_REGS-1:0] pending, busy;
    logic                stall, accept, issue;
    logic                unused_wb_hi;

    assign unused_wb_hi = ^wb_addr[ADDR_WIDTH-1:REG_IDX_W];

    // Unused read ports and non-writing destinations are forced to zero.
    always_comb begin
        cls        = op_class(instr[OP_LSB +: 4]);
        dec        = '0;
        dec.op     = instr[OP_LSB +: 4];
        dec.imm    = {{(16-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
        dec.rs1_en = (cls != CLS_NONE);
        dec.rs2_en = (cls == CLS_RR_W) || (cls == CLS_RR);
        dec.wr_en  = (cls == CLS_RR_W) || (cls == CLS_R_W);
        if (dec.rs1_en) dec.rs1 = instr[RS1_LSB +: REG_IDX_W];
        if (dec.rs2_en) dec.rs2 = instr[RS2_LSB +: REG_IDX_W];
        if (dec.wr_en)  dec.rd  = instr[RD_LSB +: REG_IDX_W];
    end

    // The held instr counts as busy even while it issues: no bypass into the scoreboard.
    always_comb begin
        busy = pending;
        if (out_valid_q && slot_q.wr_en) busy[slot_q.rd] = 1'b1;
        stall = (dec.rs1_en && busy[dec.rs1]) ||
                (dec.rs2_en && busy[dec.rs2]) ||
                (dec.wr_en  && busy[dec.rd]);
    end

    assign in_ready = !rst && !stall && (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign issue    = out_valid_q && out_ready && !flush;

    always_comb begin
        slot_d      = slot_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            slot_d      = dec;
            out_valid_d = 1'b1;
        end else if (flush || issue) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            out_valid_q <= out_valid_d;
        end
    end

    scoreboard #(.NUM_REGS(NUM_REGS), .IDX_W(REG_IDX_W)) u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (issue && slot_q.wr_en),
        .set_idx (slot_q.rd),
        .clr_en  (wb_en),
        .clr_idx (wb_addr[REG_IDX_W-1:0]),
        .pending (pending)
    );

    assign out_valid = out_valid_q;
    assign rs1_en    = slot_q.rs1_en;
    assign rs2_en    = slot_q.rs2_en;
    assign rd_addr1  = {{PAD_W{1'b0}}, slot_q.rs1};
    assign rd_addr2  = {{PAD_W{1'b0}}, slot_q.rs2};
    assign dst_wr_en = slot_q.wr_en;
    assign dst_addr  = {{PAD_W{1'b0}}, slot_q.rd};
    assign op        = slot_q.op;
    assign imm       = slot_q.imm;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: handshake, hazards, backpressure, flush, decode corners.
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, flush, wb_en;
    logic [15:0] instr;
    logic [5:0]  wb_addr;
    logic        in_ready, out_valid, rs1_en, rs2_en, dst_wr_en;
    logic [5:0]  rd_addr1, rd_addr2, dst_addr;
    logic [3:0]  op;
    logic [15:0] imm;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
        .rs1_en(rs1_en), .rs2_en(rs2_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .dst_wr_en(dst_wr_en), .dst_addr(dst_addr), .op(op), .imm(imm),
        .wb_en(wb_en), .wb_addr(wb_addr)
    );

    function automatic logic [15:0] mk(input logic [3:0] o, input logic [1:0] rd,
                                       input logic [1:0] s1, input logic [1:0] s2,
                                       input logic [5:0] im);
        return {o, rd, s1, s2, im};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1; in_valid = 0; out_ready = 0; flush = 0; wb_en = 0; wb_addr = 0;
        instr = 16'h0000;

        // reset
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rs_en", {rs1_en, rs2_en}, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 0;
        tick();
        chk("rst_pending", dut.u_sb.pending_q, 0);
        chk("rst_out_valid2", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);

        // ALU_R r1 <= r2, r3
        in_valid = 1; out_ready = 1; instr = mk(4'h1, 2'd1, 2'd2, 2'd3, 6'd5);
        #1 chk("alur_in_ready", in_ready, 1);
        tick();
        in_valid = 0;
        chk("alur_out_valid", out_valid, 1);
        chk("alur_addrs", {rd_addr1, rd_addr2}, {6'd2, 6'd3});
        chk("alur_en", {rs1_en, rs2_en}, 2'b11);
        chk("alur_dst", {dst_wr_en, dst_addr}, {1'b1, 6'd1});
        chk("alur_op_imm", {op, imm}, {4'h1, 16'h0005});
        tick();
        chk("alur_pending", dut.u_sb.pending_q, 4'b0010);
        chk("alur_drained", out_valid, 0);

        // RAW: ALU_I r0 <= r1 waits for writeback of r1
        in_valid = 1; instr = mk(4'h2, 2'd0, 2'd1, 2'd2, 6'd0);
        #1 chk("raw_stall0", in_ready, 0);
        tick();
        chk("raw_stall1", in_ready, 0);
        wb_en = 1; wb_addr = 6'd1;
        #1 chk("raw_stall_wb", in_ready, 0);
        tick();
        wb_en = 0;
        #1 chk("raw_ready", in_ready, 1);
        chk("raw_pending", dut.u_sb.pending_q, 0);
        out_ready = 0;
        tick();
        chk("raw_out_valid", out_valid, 1);
        chk("raw_addrs", {rs1_en, rs2_en, rd_addr1, rd_addr2}, {2'b10, 6'd1, 6'd0});
        chk("raw_dst", {dst_wr_en, dst_addr}, {1'b1, 6'd0});

        // backpressure with ALU_R r2 <= r3, r3 waiting
        instr = mk(4'h1, 2'd2, 2'd3, 2'd3, 6'd0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_in_ready", in_ready, 0);
            tick();
            chk("bp_hold", {out_valid, dst_addr, rd_addr1, op}, {1'b1, 6'd0, 6'd1, 4'h2});
        end
        out_ready = 1;
        #1 chk("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 0;
        chk("bp_next", {out_valid, dst_addr, rd_addr1, rd_addr2}, {1'b1, 6'd2, 6'd3, 6'd3});
        chk("bp_pending", dut.u_sb.pending_q, 4'b0001);
        tick();
        chk("bp_pending2", {out_valid, dut.u_sb.pending_q}, {1'b0, 4'b0101});
        wb_en = 1; wb_addr = 6'd0;
        tick();
        wb_en = 0;
        chk("wb_clear", dut.u_sb.pending_q, 4'b0100);

        // flush a held STORE r1, r3 while a new instr is offered
        out_ready = 0; in_valid = 1; instr = mk(4'h4, 2'd0, 2'd1, 2'd3, 6'd0);
        tick();
        chk("st_held", {out_valid, dst_wr_en, rs1_en, rs2_en}, 4'b1011);
        instr = mk(4'h1, 2'd3, 2'd0, 2'd1, 6'd0); flush = 1;
        #1 chk("flush_in_ready", in_ready, 0);
        tick();
        flush = 0; in_valid = 0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_pending", dut.u_sb.pending_q, 4'b0100);

        // imm sign extension, undefined op, JUMP
        out_ready = 1; in_valid = 1; instr = mk(4'h2, 2'd3, 2'd0, 2'd0, 6'b100000);
        tick();
        chk("imm_neg", {imm, dst_addr}, {16'hFFE0, 6'd3});
        instr = mk(4'hF, 2'd1, 2'd2, 2'd3, 6'd0);
        #1 chk("undef_ready", in_ready, 1);
        tick();
        chk("undef_dec", {out_valid, rs1_en, rs2_en, dst_wr_en, rd_addr1, op},
            {4'b1000, 6'd0, 4'hF});
        chk("undef_pending", dut.u_sb.pending_q, 4'b1100);
        instr = mk(4'h6, 2'd2, 2'd3, 2'd2, 6'h1F);
        #1 chk("jump_ready", in_ready, 1);
        tick();
        chk("jump_dec", {out_valid, op, imm, rs1_en, dst_wr_en}, {1'b1, 4'h6, 16'h001F, 2'b00});

        // set and clear of the same bit in one cycle: set wins
        instr = mk(4'h2, 2'd1, 2'd0, 2'd0, 6'd0);
        tick();
        in_valid = 0; wb_en = 1; wb_addr = 6'd1;
        tick();
        wb_en = 0;
        chk("set_wins", dut.u_sb.pending_q, 4'b1110);

        // mid-operation reset
        in_valid = 1; out_ready = 0; instr = mk(4'h6, 2'd0, 2'd0, 2'd0, 6'd0);
        tick();
        rst = 1; in_valid = 0;
        #1 chk("midrst_in_ready", in_ready, 0);
        tick();
        rst = 0;
        chk("midrst_state", {out_valid, dut.u_sb.pending_q}, 5'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
